// File: rtl/sync_fifo_param_pkg.sv
// Shared constants and helpers for sync_fifo_param.
// Define SYNC_FIFO_FWFT_EN to build the first-word-fall-through read mode.
package sync_fifo_param_pkg;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_DEPTH  = 8;

`ifdef SYNC_FIFO_FWFT_EN
   localparam bit FWFT_MODE = 1'b1;
`else
   localparam bit FWFT_MODE = 1'b0;
`endif

   function automatic int clog2(input int value);
      int result;
      result = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         result = result + 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// Handshake, data and status bundle between a FIFO user (master) and the FIFO (slave).
interface sync_fifo_param_if
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
);
   localparam int CNT_W = clog2(DEPTH) + 1;

   logic              clr;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic              rd_en;
   logic [DATA_W-1:0] rd_data;
   logic              full;
   logic              almost_full;
   logic              empty;
   logic              almost_empty;
   logic [CNT_W-1:0]  count;
   logic              overflow;
   logic              underflow;

   modport master (
      output clr, wr_en, wr_data, rd_en,
      input  rd_data, full, almost_full, empty, almost_empty, count, overflow, underflow
   );

   modport slave (
      input  clr, wr_en, wr_data, rd_en,
      output rd_data, full, almost_full, empty, almost_empty, count, overflow, underflow
   );

endinterface

// File: rtl/ram_dp_param.sv
// Simple dual-port RAM: registered write, read either registered (RD_REG=1) or combinational.
module ram_dp_param #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int RD_REG = 1,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              wr_en,
   input  logic [AW-1:0]     wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [AW-1:0]     rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   generate
      if (RD_REG != 0) begin : g_rd_reg
         always_ff @(posedge clk) begin
            if (rd_en) begin
               rd_data <= mem[rd_addr];
            end
         end
      end else begin : g_rd_comb
         assign rd_data = mem[rd_addr];
      end
   endgenerate

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised synchronous FIFO with occupancy count, flush and sticky error flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is 1-cycle registered read.
module sync_fifo_param
   import sync_fifo_param_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int DEPTH      = DEF_DEPTH,
   parameter int AFULL_LVL  = DEPTH - 2,
   parameter int AEMPTY_LVL = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   sync_fifo_param_if.slave  bus
);

   localparam int AW    = clog2(DEPTH);
   localparam int CNT_W = AW + 1;
   localparam int PTR_W = AW + 1;

   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;
   logic              underflow_q, underflow_d;
   logic              full, empty, wen, ren;
   logic              ram_wen, ram_ren;
   logic [DATA_W-1:0] ram_rd_data;

   assign full  = (count_q == CNT_W'(DEPTH));
   assign empty = (count_q == '0);
   assign wen   = bus.wr_en & ~full;
   assign ren   = bus.rd_en & ~empty;

   // A flush wins over both ports, so the RAM must not see the request either.
   assign ram_wen = wen & ~bus.clr;
   assign ram_ren = ren & ~bus.clr;

   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      overflow_d  = overflow_q;
      underflow_d = underflow_q;
      if (bus.clr) begin
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         count_d     = '0;
         overflow_d  = 1'b0;
         underflow_d = 1'b0;
      end else begin
         if (wen) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (ren) rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d     = count_q + CNT_W'(wen) - CNT_W'(ren);
         overflow_d  = overflow_q | (bus.wr_en & full);
         underflow_d = underflow_q | (bus.rd_en & empty);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         overflow_q  <= overflow_d;
         underflow_q <= underflow_d;
      end
   end

   ram_dp_param #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .RD_REG (FWFT_MODE ? 0 : 1),
      .AW     (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (ram_wen),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (bus.wr_data),
      .rd_en   (ram_ren),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (ram_rd_data)
   );

`ifdef SYNC_FIFO_FWFT_EN
   assign bus.rd_data = empty ? '0 : ram_rd_data;
`else
   logic rd_seen_q, rd_seen_d;

   // The RAM read register has no reset, so rd_data reads 0 until the first real pop.
   assign rd_seen_d = rd_seen_q | ram_ren;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_seen_q <= 1'b0;
      end else begin
         rd_seen_q <= rd_seen_d;
      end
   end

   assign bus.rd_data = rd_seen_q ? ram_rd_data : '0;
`endif

   assign bus.full         = full;
   assign bus.empty        = empty;
   assign bus.almost_full  = (int'(count_q) >= AFULL_LVL);
   assign bus.almost_empty = (int'(count_q) <= AEMPTY_LVL);
   assign bus.count        = count_q;
   assign bus.overflow     = overflow_q;
   assign bus.underflow    = underflow_q;

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised synchronous FIFO; next generation of the router input-buffer FIFO. Width, depth and almost-thresholds are generic.
- Adds an occupancy count output, a synchronous flush, and sticky overflow/underflow error flags.
- Optional first-word-fall-through (FWFT) read mode.
- Used as the per-port / per-VC input buffer in the mesh router, one clock domain.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 8, entries; power of two, >= 2
AFULL_LVL, DEPTH-2, almost_full asserted when count >= AFULL_LVL
AEMPTY_LVL, 1, almost_empty asserted when count <= AEMPTY_LVL
CNT_W, $clog2(DEPTH)+1, derived; count width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, asynchronous, active-low
clr  in  1  synchronous flush: pointers, count and error flags to 0; RAM contents don't-care
wr_en  in  1  write request
wr_data  in  DATA_W  write data
rd_en  in  1  read (pop) request
rd_data  out  DATA_W  read data
full  out  1  count == DEPTH
almost_full  out  1  count >= AFULL_LVL
empty  out  1  count == 0
almost_empty  out  1  count <= AEMPTY_LVL
count  out  CNT_W  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Clock/reset are fixed: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - Pointers and count = 0, so empty=1, almost_empty=1, full=0.
  - almost_full=0 unless AFULL_LVL==0.
  - overflow=0, underflow=0, rd_data=0.
- Pointers:
  - wr_ptr and rd_ptr are $clog2(DEPTH)+1 bits, with the MSB as wrap bit.
  - Address = low bits; wrap is natural modulo-2·DEPTH roll-over.
- Qualified enables:
  - wen = wr_en & ~full.
  - ren = rd_en & ~empty.
  - Flags are evaluated on pre-edge state.
- Count update, registered:
  - count += wen - ren.
  - Simultaneous wen & ren leaves count unchanged.
- Status flags: full, empty, almost_full and almost_empty are combinational decodes of the count register. No glitch-free requirement.
- Full boundary:
  - Write while full is dropped and sets overflow, even if rd_en is also high that cycle.
  - No write pass-through; a read while full still proceeds.
- Empty boundary:
  - Read while empty is ignored, rd_data holds, underflow is set.
  - A simultaneous write while empty proceeds; no read-through.
- Flush precedence:
  - clr has priority over wr_en/rd_en in the same cycle.
  - After clr: empty next cycle, error flags 0.
- Standard mode (macro undefined):
  - rd_data is registered, valid the cycle after a qualified ren (1-cycle latency).
  - Holds its value otherwise.
- Error flags: clear only via rst_n or clr.
- Storage:
  - RAM has a registered write.
  - Read is a synchronous 1-cycle read, or a combinational read in FWFT mode, selected by a sub-module parameter.

Optional Feature:
Macro: SYNC_FIFO_FWFT_EN
- Defined (FWFT mode):
  - rd_data always shows the head entry while empty=0; rd_en pops it combinationally.
  - The next head is visible in the same cycle the pop completes.
  - A word written into an empty FIFO is visible on rd_data one cycle after the write edge; empty falls at the same point.
  - rd_data is don't-care while empty.
  - Capacity stays DEPTH, and count includes the head entry.
- Undefined: standard mode as above.

Decomposition:
- Shared include (global.v):
  - Default DATA_WIDTH and FIFO depth constants.
  - A clog2 constant function.
  - The SYNC_FIFO_FWFT_EN macro guard.
- One sub-module: ram_dp_param.
  - Parameters: DATA_W, DEPTH, RD_REG (1 = registered read, 0 = combinational).
  - Ports: clk, wr_en, wr_addr, wr_data, rd_en, rd_addr, rd_data.
- Pointer/count/flag logic stays in sync_fifo_param.

Test Plan:
- Reset, then 8 writes 0x00000001..0x00000008 (DEPTH=8), then 8 reads.
  - Data returns in order 1..8.
  - count goes 0→8→0.
  - full=1 exactly at count 8; empty=1 at end.
  - Standard mode: data appears 1 cycle after each rd_en.
- Fill to full, then assert wr_en+rd_en together for 1 cycle.
  - Read pops 1; write dropped; count=7; overflow=1 and remains set.
- From empty, assert wr_en=1 and rd_en=1 with wr_data=0xA5A5A5A5.
  - count=1, underflow=1, rd_data unchanged.
  - Next cycle a read returns 0xA5A5A5A5.
- Wrap-around: 20 cycles of interleaved single write/read.
  - count stays ≤1; data stream matches 20 written values.
  - Pointer wrap bit toggles twice with no false full/empty.
- Thresholds (AFULL_LVL=6, AEMPTY_LVL=1):
  - almost_full rises on 6th write.
  - almost_empty falls on 2nd write and rises again when count returns to 1.
- clr asserted with count=5 plus a simultaneous wr_en.
  - Next cycle count=0, empty=1, overflow=underflow=0, write discarded.
- Async reset mid-burst: all outputs return to reset values without a clock edge.
